// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Two-requester AXI4 read-channel arbiter. Port 0 is the display-critical VGA
// line fetcher, port 1 a secondary reader (DMA/blitter). One burst is in
// flight at a time: a requester is granted in IDLE, its AR is latched and
// replayed to memory in ADDR, and every R beat is routed back to it in DATA
// until rlast.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   io_in{0,1}_ar*          requester read-address channels (49-bit bits)
//   io_in{0,1}_r*           requester read-data channels (71-bit bits)
//   io_out_ar*, io_out_r*   shared memory master channels, same packing
//   busy                    arbiter not in IDLE
//   grant                   index of the current / last granted port
//   len_err                 sticky: a burst's beat count disagreed with arlen+1
//
// AR packing: {araddr[31:0], arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0]}
// R  packing: {rdata[63:0], rresp[1:0], rlast, rid[3:0]}
module axi_rd_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_SKIP   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in0_arvalid,
    output logic        io_in0_arready,
    input  logic [48:0] io_in0_arbits,
    output logic        io_in0_rvalid,
    input  logic        io_in0_rready,
    output logic [70:0] io_in0_rbits,
    input  logic        io_in1_arvalid,
    output logic        io_in1_arready,
    input  logic [48:0] io_in1_arbits,
    output logic        io_in1_rvalid,
    input  logic        io_in1_rready,
    output logic [70:0] io_in1_rbits,
    output logic        io_out_arvalid,
    input  logic        io_out_arready,
    output logic [48:0] io_out_arbits,
    input  logic        io_out_rvalid,
    output logic        io_out_rready,
    input  logic [70:0] io_out_rbits,
    output logic        busy,
    output logic        grant,
    output logic        len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state_reg;
    logic [48:0] arbits_reg;
    logic        arvalid_reg;
    logic        grant_reg;
    logic        last_tie_reg;
    logic [7:0]  skip_cnt_reg;
    logic [8:0]  beat_cnt_reg;
    logic        len_err_reg;

    // ---------------- request arbitration ----------------
    logic tie;
    logic tie_pick;
    logic winner;
    logic accept;

    always_comb begin
        tie = io_in0_arvalid & io_in1_arvalid;
        if (FIXED_PRIO != 0) begin
            // Port 1 only breaks through after a run of lost ties, so the
            // display fetcher keeps priority without starving the other port.
            tie_pick = (MAX_SKIP != 0) && (skip_cnt_reg == 8'(MAX_SKIP));
        end else begin
            tie_pick = ~last_tie_reg;
        end
        winner = tie ? tie_pick : io_in1_arvalid;
        accept = (state_reg == IDLE) & (io_in0_arvalid | io_in1_arvalid);
    end

    assign io_in0_arready = (state_reg == IDLE) & io_in0_arvalid & ~winner;
    assign io_in1_arready = (state_reg == IDLE) & io_in1_arvalid & winner;

    // ---------------- read data routing ----------------
    logic [1:0]  port_sel;
    logic [1:0]  rready_vec;
    logic [1:0]  rvalid_vec;
    logic [70:0] rbits_vec [2];

    assign rready_vec = {io_in1_rready, io_in0_rready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rport
            assign port_sel[gi]   = (state_reg == DATA) && (grant_reg == 1'(gi));
            assign rvalid_vec[gi] = port_sel[gi] & io_out_rvalid;
            assign rbits_vec[gi]  = port_sel[gi] ? io_out_rbits : '0;
        end
    endgenerate

    assign io_in0_rvalid  = rvalid_vec[0];
    assign io_in1_rvalid  = rvalid_vec[1];
    assign io_in0_rbits   = rbits_vec[0];
    assign io_in1_rbits   = rbits_vec[1];
    assign io_out_rready  = |(port_sel & rready_vec);

    logic       beat;
    logic       rlast;
    logic [8:0] arlen_ext;

    assign beat      = (state_reg == DATA) & io_out_rvalid & io_out_rready;
    assign rlast     = io_out_rbits[4];
    assign arlen_ext = {1'b0, arbits_reg[12:5]};

    assign io_out_arvalid = arvalid_reg;
    assign io_out_arbits  = arbits_reg;
    assign busy           = (state_reg != IDLE);
    assign grant          = grant_reg;
    assign len_err        = len_err_reg;

    // ---------------- control ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            arbits_reg   <= '0;
            arvalid_reg  <= 1'b0;
            grant_reg    <= 1'b0;
            last_tie_reg <= 1'b1;
            skip_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            len_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        arbits_reg   <= winner ? io_in1_arbits : io_in0_arbits;
                        grant_reg    <= winner;
                        beat_cnt_reg <= '0;
                        arvalid_reg  <= 1'b1;
                        state_reg    <= ADDR;
                        if (tie) begin
                            last_tie_reg <= winner;
                        end
                        if (winner) begin
                            skip_cnt_reg <= '0;
                        end else if (tie && skip_cnt_reg != 8'hFF) begin
                            skip_cnt_reg <= skip_cnt_reg + 8'd1;
                        end
                    end
                end
                ADDR: begin
                    if (io_out_arready) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        // Saturate so a runaway memory cannot wrap the count
                        // back into the legal range and hide the error.
                        if (beat_cnt_reg != 9'h1FF) begin
                            beat_cnt_reg <= beat_cnt_reg + 9'd1;
                        end
                        if (rlast) begin
                            state_reg <= IDLE;
                            if (beat_cnt_reg != arlen_ext) begin
                                len_err_reg <= 1'b1;
                            end
                        end else if (beat_cnt_reg > arlen_ext) begin
                            // Overlong burst: flag it, keep forwarding until rlast.
                            len_err_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Scoreboard bench for axi_rd_arbiter. A driver process plays both requesters
// (request queues) and the memory (burst queue with random AR/R stalls). A
// monitor process keeps a transaction-level model of the arbiter (who should
// win, which port owns the data phase, which beats must come back) and
// compares the DUT every cycle. A second instance with FIXED_PRIO=1 runs
// saturated to check the skip pattern.
module tb_axi_rd_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        in0_arvalid, in1_arvalid, in0_rready, in1_rready;
    logic [48:0] in0_arbits, in1_arbits;
    logic        in0_arready, in1_arready, in0_rvalid, in1_rvalid;
    logic [70:0] in0_rbits, in1_rbits;
    logic        out_arvalid, out_arready, out_rvalid, out_rready;
    logic [48:0] out_arbits;
    logic [70:0] out_rbits;
    logic        busy, grant, len_err;

    axi_rd_arbiter #(.FIXED_PRIO(0), .MAX_SKIP(3)) dut (
        .clock(clock), .reset(reset),
        .io_in0_arvalid(in0_arvalid), .io_in0_arready(in0_arready), .io_in0_arbits(in0_arbits),
        .io_in0_rvalid(in0_rvalid), .io_in0_rready(in0_rready), .io_in0_rbits(in0_rbits),
        .io_in1_arvalid(in1_arvalid), .io_in1_arready(in1_arready), .io_in1_arbits(in1_arbits),
        .io_in1_rvalid(in1_rvalid), .io_in1_rready(in1_rready), .io_in1_rbits(in1_rbits),
        .io_out_arvalid(out_arvalid), .io_out_arready(out_arready), .io_out_arbits(out_arbits),
        .io_out_rvalid(out_rvalid), .io_out_rready(out_rready), .io_out_rbits(out_rbits),
        .busy(busy), .grant(grant), .len_err(len_err)
    );

    // Saturated fixed-priority instance
    logic        f_one = 1'b1;
    logic [48:0] f_arbits = '0;
    logic [70:0] f_rbits_in = 71'h10;   // single-beat bursts: rlast set
    logic        f0_arready, f1_arready, f0_rvalid, f1_rvalid;
    logic [70:0] f0_rbits, f1_rbits;
    logic        f_out_arvalid, f_out_rready, f_busy, f_grant, f_len_err;
    logic [48:0] f_out_arbits;

    axi_rd_arbiter #(.FIXED_PRIO(1), .MAX_SKIP(3)) dut_fix (
        .clock(clock), .reset(reset),
        .io_in0_arvalid(f_one), .io_in0_arready(f0_arready), .io_in0_arbits(f_arbits),
        .io_in0_rvalid(f0_rvalid), .io_in0_rready(f_one), .io_in0_rbits(f0_rbits),
        .io_in1_arvalid(f_one), .io_in1_arready(f1_arready), .io_in1_arbits(f_arbits),
        .io_in1_rvalid(f1_rvalid), .io_in1_rready(f_one), .io_in1_rbits(f1_rbits),
        .io_out_arvalid(f_out_arvalid), .io_out_arready(f_one), .io_out_arbits(f_out_arbits),
        .io_out_rvalid(f_one), .io_out_rready(f_out_rready), .io_out_rbits(f_rbits_in),
        .busy(f_busy), .grant(f_grant), .len_err(f_len_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction helpers ----------------
    function automatic logic [48:0] mk_ar(input logic [31:0] addr, input logic [3:0] id,
                                          input logic [7:0] len);
        return {addr, id, len, 3'd3, 2'd1};
    endfunction

    // Memory behaviour: top address nibble E returns rlast early (beat 3),
    // nibble F returns two extra beats; anything else is a correct burst.
    function automatic int n_beats(input logic [48:0] ar);
        logic [3:0] sel;
        int         len;
        sel = ar[48:45];
        len = int'(ar[12:5]);
        if (sel == 4'hE && len >= 4) return 4;
        if (sel == 4'hF) return len + 3;
        return len + 1;
    endfunction

    function automatic logic [70:0] mk_beat(input logic [48:0] ar, input int i);
        logic [31:0] addr;
        logic [3:0]  id;
        logic        last;
        addr = ar[48:17];
        id   = ar[16:13];
        last = (i == n_beats(ar) - 1);
        return {addr, 23'h0, 9'(i), 2'(i) ^ id[1:0], last, id};
    endfunction

    // ---------------- stimulus state ----------------
    logic [48:0] pq0[$];
    logic [48:0] pq1[$];
    logic [48:0] mq[$];
    int          mbeat  = 0;
    logic        rr_mode = 1'b0;

    // ---------------- model state (monitor) ----------------
    logic        m_idle = 1'b1, m_addr = 1'b0, m_data = 1'b0;
    logic        m_port = 1'b0, m_last_tie = 1'b1, m_len_err = 1'b0;
    logic [48:0] exp_ar[$];
    logic [70:0] exp_b[$];
    logic        exp_bad[$];
    int          beats_seen = 0;
    int          bursts_done = 0;
    int          k_fix = 0;

    // ---------------- driver: requesters + memory ----------------
    initial begin : driver
        logic        hs0, hs1, hsa, hsr, rst_s;
        logic [48:0] ar_s;
        int          cyc;
        cyc = 0;
        in0_arvalid = 0; in1_arvalid = 0; in0_arbits = '0; in1_arbits = '0;
        in0_rready = 0; in1_rready = 0; out_arready = 0; out_rvalid = 0; out_rbits = '0;
        forever begin
            @(negedge clock);
            hs0   = in0_arvalid & in0_arready;
            hs1   = in1_arvalid & in1_arready;
            hsa   = out_arvalid & out_arready;
            hsr   = out_rvalid & out_rready;
            ar_s  = out_arbits;
            rst_s = reset;
            @(posedge clock);
            #1;
            cyc++;
            if (rst_s) begin
                mq.delete();
                mbeat = 0;
            end else begin
                if (hs0 && pq0.size() > 0) void'(pq0.pop_front());
                if (hs1 && pq1.size() > 0) void'(pq1.pop_front());
                if (hsa) mq.push_back(ar_s);
                if (hsr && mq.size() > 0) begin
                    mbeat++;
                    if (mbeat == n_beats(mq[0])) begin
                        void'(mq.pop_front());
                        mbeat = 0;
                    end
                end
            end
            in0_arvalid = (pq0.size() > 0);
            in0_arbits  = in0_arvalid ? pq0[0] : '0;
            in1_arvalid = (pq1.size() > 0);
            in1_arbits  = in1_arvalid ? pq1[0] : '0;
            if (rr_mode) begin
                in0_rready = cyc[0];
                in1_rready = cyc[0];
            end else begin
                in0_rready = ($urandom % 4) != 0;
                in1_rready = ($urandom % 4) != 0;
            end
            out_arready = $urandom % 2;
            out_rvalid  = (mq.size() > 0) && (($urandom % 10) < 7);
            out_rbits   = out_rvalid ? mk_beat(mq[0], mbeat) : '0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        v0, v1, w, exp_r0, exp_r1, hs;
        logic [48:0] ar;
        logic [70:0] act_b, eb;
        logic        bad;
        int          nb;
        int          len;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_idle = 1; m_addr = 0; m_data = 0; m_port = 0; m_last_tie = 1; m_len_err = 0;
                exp_ar.delete(); exp_b.delete(); exp_bad.delete();
            end else begin
                chk("busy", 71'(busy), 71'(!m_idle));
                chk("len_err", 71'(len_err), 71'(m_len_err));
                if (!m_idle) chk("grant", 71'(grant), 71'(m_port));
                chk("out_arvalid", 71'(out_arvalid), 71'(m_addr));
                chk("out_rready", 71'(out_rready),
                    71'(m_data && (m_port ? in1_rready : in0_rready)));
                chk("in0_rvalid", 71'(in0_rvalid), 71'(m_data && !m_port && out_rvalid));
                chk("in1_rvalid", 71'(in1_rvalid), 71'(m_data && m_port && out_rvalid));
                if (!(m_data && !m_port)) chk("in0_rbits_idle", in0_rbits, '0);
                if (!(m_data && m_port))  chk("in1_rbits_idle", in1_rbits, '0);

                v0 = in0_arvalid; v1 = in1_arvalid;
                w = (v0 && v1) ? !m_last_tie : v1;
                exp_r0 = m_idle && v0 && !w;
                exp_r1 = m_idle && v1 && w;
                chk("arready", 71'({in1_arready, in0_arready}), 71'({exp_r1, exp_r0}));

                if (m_idle) begin
                    if (v0 || v1) begin
                        if (v0 && v1) m_last_tie = w;
                        m_port = w;
                        m_idle = 0;
                        m_addr = 1;
                        exp_ar.push_back(w ? in1_arbits : in0_arbits);
                    end
                end else if (m_addr && out_arvalid && out_arready) begin
                    ar = exp_ar.pop_front();
                    chk("out_arbits", 71'(out_arbits), 71'(ar));
                    nb  = n_beats(ar);
                    len = int'(ar[12:5]);
                    for (int i = 0; i < nb; i++) begin
                        exp_b.push_back(mk_beat(ar, i));
                        exp_bad.push_back((i > len) || (i == nb - 1 && i != len));
                    end
                    m_addr = 0;
                    m_data = 1;
                end else if (m_data) begin
                    hs    = m_port ? (in1_rvalid & in1_rready) : (in0_rvalid & in0_rready);
                    act_b = m_port ? in1_rbits : in0_rbits;
                    if (hs) begin
                        beats_seen++;
                        if (exp_b.size() == 0) begin
                            chk("beat_unexpected", act_b, '0);
                        end else begin
                            eb  = exp_b.pop_front();
                            bad = exp_bad.pop_front();
                            chk("rbits", act_b, eb);
                            if (bad) m_len_err = 1;
                            if (eb[4]) begin
                                m_data = 0;
                                m_idle = 1;
                                bursts_done++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Fixed-priority instance: port 1 wins every 4th tie when MAX_SKIP=3
    initial begin : fix_monitor
        forever begin
            @(negedge clock);
            if (!reset && k_fix < 8 && (f0_arready || f1_arready)) begin
                chk("fixed_grant", 71'({f1_arready, f0_arready}),
                    71'((k_fix % 4 == 3) ? 2'b10 : 2'b01));
                k_fix++;
            end
        end
    end

    // ---------------- sequencing ----------------
    task automatic wait_idle(input string name);
        logic ok;
        ok = 0;
        for (int t = 0; t < 6000; t++) begin
            @(negedge clock);
            #1;
            if (pq0.size() == 0 && pq1.size() == 0 && mq.size() == 0 && m_idle &&
                exp_ar.size() == 0 && exp_b.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(name, 71'(ok), 71'(1));
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1;
        pq0.delete();
        pq1.delete();
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin : main
        int b0;
        int d0;
        logic ok;
        reset = 1;
        repeat (4) @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        chk("rst_grant", 71'(grant), '0);
        chk("rst_out_arbits", 71'(out_arbits), '0);
        chk("rst_len_err", 71'(len_err), '0);

        // 1: long burst on port 0
        b0 = beats_seen;
        pq0.push_back(mk_ar(32'h8000_0000, 4'd1, 8'd199));
        wait_idle("t1_drain");
        chk("t1_beats", 71'(beats_seen - b0), 71'(200));
        $display("t1 long burst port0: %0d beats", beats_seen - b0);

        // 2: round-robin tie breaking with single-beat bursts
        for (int i = 0; i < 6; i++) begin
            pq0.push_back(mk_ar(32'h0100_0000 + 32'(i * 64), 4'd2, 8'd0));
            pq1.push_back(mk_ar(32'h0200_0000 + 32'(i * 64), 4'd3, 8'd0));
        end
        wait_idle("t2_drain");
        $display("t2 round-robin ties: %0d bursts done", bursts_done);

        // 4: toggling rready on the granted port
        rr_mode = 1;
        b0 = beats_seen;
        pq1.push_back(mk_ar(32'h0300_0000, 4'd4, 8'd15));
        wait_idle("t4_drain");
        chk("t4_beats", 71'(beats_seen - b0), 71'(16));
        rr_mode = 0;
        $display("t4 toggled rready: %0d beats", beats_seen - b0);

        // random mix of both requesters
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 2)
                pq0.push_back(mk_ar({4'($urandom_range(0, 13)), 28'($urandom)},
                                    4'($urandom), 8'($urandom_range(0, 15))));
            else
                pq1.push_back(mk_ar({4'($urandom_range(0, 13)), 28'($urandom)},
                                    4'($urandom), 8'($urandom_range(0, 15))));
            repeat ($urandom % 6) @(posedge clock);
        end
        wait_idle("rand_drain");
        $display("random phase: %0d bursts done", bursts_done);

        // 5: early rlast on beat 3 of arlen=7
        pq0.push_back(mk_ar(32'hE000_0000, 4'd2, 8'd7));
        wait_idle("t5_drain");
        chk("t5_len_err", 71'(len_err), 71'(1));
        repeat (3) @(negedge clock);
        chk("t5_len_err_sticky", 71'(len_err), 71'(1));
        chk("t5_busy", 71'(busy), '0);
        $display("t5 early rlast: len_err=%0b", len_err);
        do_reset();
        @(negedge clock);
        chk("t5_len_err_cleared", 71'(len_err), '0);

        // overlong burst (two beats past arlen+1)
        pq1.push_back(mk_ar(32'hF000_1000, 4'd3, 8'd2));
        wait_idle("ovl_drain");
        chk("ovl_len_err", 71'(len_err), 71'(1));
        $display("overlong burst: len_err=%0b", len_err);
        do_reset();

        // 6: reset in the middle of the data phase
        b0 = beats_seen;
        pq0.push_back(mk_ar(32'h1000_0000, 4'd5, 8'd99));
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            #1;
            if (beats_seen - b0 >= 50) begin
                ok = 1;
                break;
            end
        end
        chk("t6_reach_beat50", 71'(ok), 71'(1));
        do_reset();
        @(negedge clock);
        chk("t6_busy", 71'(busy), '0);
        chk("t6_valids", 71'({out_arvalid, out_rready, in0_rvalid, in1_rvalid}), '0);
        d0 = bursts_done;
        pq1.push_back(mk_ar(32'h2000_0000, 4'd6, 8'd3));
        wait_idle("t6_drain");
        chk("t6_new_burst", 71'(bursts_done - d0), 71'(1));
        $display("t6 reset mid-burst: new burst done=%0d", bursts_done - d0);

        chk("fixed_count", 71'(k_fix), 71'(8));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
